// File: rtl/svm_mul_pkg.sv
// Shared constants and helpers for the SVM multiplier pipeline and its
// saturation stage. LV/L are the figures for the default operand width.
package svm_mul_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Number of nodes left in the adder tree after lvl pairwise levels.
  function automatic int tree_cnt(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  // Keeps elaborated indices in range on branches that are never taken.
  function automatic int clamp_idx(input int i, input int n);
    return (i < n) ? i : 0;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  localparam int IN_W_DEF = 17;
  localparam int LV       = clog2(IN_W_DEF);
  localparam int L        = LV + 4;

endpackage

// File: rtl/svm_mul_pipe_if.sv
// Operand/result bundle between operand fetch, the multiplier and the
// accumulator. master = producer/consumer side, slave = multiplier.
interface svm_mul_pipe_if #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 32
);
  logic                    en;
  logic                    in_valid;
  logic signed [IN_W-1:0]  mul_a;
  logic signed [IN_W-1:0]  mul_b;
  logic                    flush;
  logic                    out_valid;
  logic signed [OUT_W-1:0] data_out;
  logic                    sat_flag;
  logic                    busy;

  modport master (
    output en, in_valid, mul_a, mul_b, flush,
    input  out_valid, data_out, sat_flag, busy
  );

  modport slave (
    input  en, in_valid, mul_a, mul_b, flush,
    output out_valid, data_out, sat_flag, busy
  );
endinterface

// File: rtl/svm_mul_sat.sv
// Combinational fixed-point rescale and saturation of a signed product.
// SVM_MUL_ROUND_EN: round half up before the shift; otherwise floor.
module svm_mul_sat
  import svm_mul_pkg::*;
#(
  parameter int PW    = 34,
  parameter int FRAC  = 16,
  parameter int OUT_W = 32
) (
  input  logic signed [PW-1:0]    p,
  output logic signed [OUT_W-1:0] value,
  output logic                    sat
);

  // One guard bit so the rounding increment can never wrap.
  localparam int EW = PW + 1;

`ifdef SVM_MUL_ROUND_EN
  localparam int RS = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [EW-1:0] HALF = (FRAC > 0) ? (EW'(1) << RS) : '0;
`endif

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] shr;

  // Round (optional), arithmetic shift, then clip to the output range.
  always_comb begin
    ext = {p[PW-1], p};
`ifdef SVM_MUL_ROUND_EN
    rnd = ext + HALF;
`else
    rnd = ext;
`endif
    shr   = rnd >>> FRAC;
    value = shr[OUT_W-1:0];
    sat   = 1'b0;
    if (longint'(shr) > sat_max(OUT_W)) begin
      value = OUT_W'(sat_max(OUT_W));
      sat   = 1'b1;
    end else if (longint'(shr) < sat_min(OUT_W)) begin
      value = OUT_W'(sat_min(OUT_W));
      sat   = 1'b1;
    end
  end

endmodule

// File: rtl/svm_mul_pipe.sv
// Fully pipelined signed fixed-point multiplier: sign-magnitude partial
// products, registered pairwise adder tree, signed product, rescale/saturate.
// Latency is clog2(IN_W)+4 enabled cycles. Optional SVM_MUL_ROUND_EN selects
// round-half-up in svm_mul_sat; latency is unaffected.
module svm_mul_pipe
  import svm_mul_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int FRAC  = 16,
  parameter int OUT_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  svm_mul_pipe_if.slave  bus
);

  localparam int PW      = 2 * IN_W;
  localparam int TREE_LV = clog2(IN_W);
  localparam int NSTG    = TREE_LV + 3;   // S0..S(LV+2); output stage is separate

  logic [IN_W-1:0]        a_abs;
  logic [IN_W-1:0]        b_abs;
  logic [TREE_LV+1:0]     sgn_pipe;
  logic [PW-1:0]          tree [0:TREE_LV][0:IN_W-1];
  logic signed [PW-1:0]   prod;
  logic [NSTG-1:0]        vld;
  logic signed [OUT_W-1:0] sat_val;
  logic                   sat_hit;

  // Valid bits shift with the data; flush clears them regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld           <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.flush) begin
      vld           <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.en) begin
      vld           <= {vld[NSTG-2:0], bus.in_valid};
      bus.out_valid <= vld[NSTG-1];
    end
  end

  assign bus.busy = |vld;

  // S0: operand magnitudes (IN_W bits so the most negative value is exact).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_abs <= '0;
      b_abs <= '0;
    end else if (bus.en) begin
      a_abs <= bus.mul_a[IN_W-1] ? IN_W'(-bus.mul_a) : IN_W'(bus.mul_a);
      b_abs <= bus.mul_b[IN_W-1] ? IN_W'(-bus.mul_b) : IN_W'(bus.mul_b);
    end
  end

  // Product sign travels alongside the magnitude through S0..S(LV+1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sgn_pipe <= '0;
    else if (bus.en)
      sgn_pipe <= {sgn_pipe[TREE_LV:0], bus.mul_a[IN_W-1] ^ bus.mul_b[IN_W-1]};
  end

  // S1: one shifted copy of |a| per set bit of |b|.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IN_W; i++) tree[0][i] <= '0;
    end else if (bus.en) begin
      for (int i = 0; i < IN_W; i++)
        tree[0][i] <= b_abs[i] ? (PW'(a_abs) << i) : '0;
    end
  end

  // S2..S(LV+1): pairwise registered adds; an odd leftover passes through.
  for (genvar l = 1; l <= TREE_LV; l++) begin : g_lvl
    localparam int NP = tree_cnt(IN_W, l - 1);
    localparam int NC = tree_cnt(IN_W, l);

    // One tree level; unused slots are held at zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < IN_W; j++) tree[l][j] <= '0;
      end else if (bus.en) begin
        for (int j = 0; j < IN_W; j++) begin
          if (j >= NC)
            tree[l][j] <= '0;
          else if (2 * j + 1 < NP)
            tree[l][j] <= tree[l-1][clamp_idx(2 * j, IN_W)]
                        + tree[l-1][clamp_idx(2 * j + 1, IN_W)];
          else
            tree[l][j] <= tree[l-1][clamp_idx(2 * j, IN_W)];
        end
      end
    end
  end

  // S(LV+2): signed product; a zero magnitude is always positive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod <= '0;
    else if (bus.en)
      prod <= (sgn_pipe[TREE_LV+1] && (tree[TREE_LV][0] != '0))
              ? -$signed(tree[TREE_LV][0]) : $signed(tree[TREE_LV][0]);
  end

  svm_mul_sat #(.PW(PW), .FRAC(FRAC), .OUT_W(OUT_W)) u_sat (
    .p     (prod),
    .value (sat_val),
    .sat   (sat_hit)
  );

  // S(LV+3): result register; bubbles and flushes leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out <= '0;
      bus.sat_flag <= 1'b0;
    end else if (bus.en && !bus.flush && vld[NSTG-1]) begin
      bus.data_out <= sat_val;
      bus.sat_flag <= sat_hit;
    end
  end

endmodule

// File: tb/tb_svm_mul_pipe.sv
// Directed bench for svm_mul_pipe: default build (FRAC=16) and a FRAC=0
// instance for saturation. Expectations follow SVM_MUL_ROUND_EN when set.
module tb_svm_mul_pipe;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  svm_mul_pipe_if #(.IN_W(17), .OUT_W(32)) bus0 ();
  svm_mul_pipe_if #(.IN_W(17), .OUT_W(32)) bus1 ();

  svm_mul_pipe #(.IN_W(17), .FRAC(16), .OUT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  svm_mul_pipe #(.IN_W(17), .FRAC(0), .OUT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Independent reference: exact product, optional round, floor shift, clip.
  function automatic logic signed [63:0] model(input longint a, input longint b,
                                               input int frac, input int ow,
                                               output bit sat);
    longint p;
    longint mx;
    longint mn;
    p = a * b;
`ifdef SVM_MUL_ROUND_EN
    if (frac > 0) p = p + (longint'(1) << (frac - 1));
`endif
    p  = p >>> frac;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -(longint'(1) << (ow - 1));
    sat = 1'b0;
    if (p > mx) begin p = mx; sat = 1'b1; end
    if (p < mn) begin p = mn; sat = 1'b1; end
    return p;
  endfunction

  task automatic drive(input int sel, input logic v, input logic signed [16:0] a,
                       input logic signed [16:0] b);
    if (sel == 0) begin
      bus0.in_valid = v; bus0.mul_a = a; bus0.mul_b = b;
    end else begin
      bus1.in_valid = v; bus1.mul_a = a; bus1.mul_b = b;
    end
  endtask

  function automatic logic get_ov(input int sel);
    return (sel == 0) ? bus0.out_valid : bus1.out_valid;
  endfunction

  // Single pair: check busy, latency in edges, value, flag, one-cycle pulse.
  task automatic run_one(input string tag, input int sel,
                         input logic signed [16:0] a, input logic signed [16:0] b,
                         input logic signed [63:0] exp_d, input logic exp_s);
    int n;
    drive(sel, 1'b1, a, b);
    @(negedge clk);
    n = 1;
    drive(sel, 1'b0, 17'sd0, 17'sd0);
    chk({tag, "_busy"}, (sel == 0) ? bus0.busy : bus1.busy, 1);
    while (!get_ov(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_data"}, (sel == 0) ? bus0.data_out : bus1.data_out, exp_d);
    chk({tag, "_sat"}, (sel == 0) ? bus0.sat_flag : bus1.sat_flag, exp_s);
    @(negedge clk);
    chk({tag, "_pulse"}, get_ov(sel), 0);
  endtask

  initial begin
    logic signed [63:0] q_d[$];
    bit                 q_s[$];
    logic signed [63:0] ed;
    logic signed [63:0] held_d;
    logic signed [16:0] ra;
    logic signed [16:0] rb;
    logic               held_ov;
    logic               held_busy;
    bit                 es;
    bit                 prev_en;
    int                 issued;
    int                 got;
    int                 cnt;

    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus0.en = 1'b1; bus0.flush = 1'b0;
    bus1.en = 1'b1; bus1.flush = 1'b0;
    drive(0, 1'b0, 17'sd0, 17'sd0);
    drive(1, 1'b0, 17'sd0, 17'sd0);
    repeat (2) @(negedge clk);
    chk("rst_ov", bus0.out_valid, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_data", bus0.data_out, 0);
    chk("rst_sat", bus0.sat_flag, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef SVM_MUL_ROUND_EN
    run_one("small_neg", 0, 17'sd3, -17'sd5, 64'sd0, 1'b0);
    run_one("round_edge", 0, 17'sd1234, -17'sd56, -64'sd1, 1'b0);
`else
    run_one("small_neg", 0, 17'sd3, -17'sd5, -64'sd1, 1'b0);
    run_one("round_edge", 0, 17'sd1234, -17'sd56, -64'sd2, 1'b0);
`endif
    run_one("max_pos", 0, 17'sd65535, 17'sd65535, 64'sd65534, 1'b0);
    run_one("min_x_max", 0, -17'sd65536, 17'sd65535, -64'sd65535, 1'b0);
    run_one("zero", 0, 17'sd0, -17'sd7, 64'sd0, 1'b0);
    run_one("f0_sat_pos", 1, -17'sd65536, -17'sd65536, 64'sd2147483647, 1'b1);
    run_one("f0_sat_neg", 1, -17'sd65536, 17'sd65535, -64'sd2147483648, 1'b1);
    run_one("f0_exact", 1, -17'sd300, 17'sd7, -64'sd2100, 1'b0);

    // Back-to-back stream with en low for three cycles mid-stream.
    issued  = 0;
    got     = 0;
    prev_en = 1'b1;
    for (int c = 0; c < 80 && got < 20; c++) begin
      if (c > 0) begin
        if (!prev_en) begin
          chk("hold_valid", bus0.out_valid, held_ov);
          chk("hold_data", bus0.data_out, held_d);
          chk("hold_busy", bus0.busy, held_busy);
        end else if (bus0.out_valid) begin
          if (q_d.size() == 0) chk("stream_extra", 1, 0);
          else begin
            chk("stream_data", bus0.data_out, q_d.pop_front());
            chk("stream_sat", bus0.sat_flag, q_s.pop_front());
            got++;
          end
        end
      end
      held_ov   = bus0.out_valid;
      held_d    = bus0.data_out;
      held_busy = bus0.busy;
      bus0.en   = !(c >= 8 && c <= 10);
      prev_en   = bus0.en;
      if (bus0.en && issued < 20) begin
        ra = 17'($urandom);
        rb = 17'($urandom);
        ed = model(longint'(ra), longint'(rb), 16, 32, es);
        q_d.push_back(ed);
        q_s.push_back(es);
        drive(0, 1'b1, ra, rb);
        issued++;
      end else begin
        drive(0, 1'b0, 17'sd0, 17'sd0);
      end
      @(negedge clk);
    end
    chk("stream_count", got, 20);
    bus0.en = 1'b1;
    drive(0, 1'b0, 17'sd0, 17'sd0);
    repeat (12) @(negedge clk);

    // Four pairs in flight, then flush with en low; the same-cycle pair drops.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 17'(100 + k), 17'sd3);
      @(negedge clk);
    end
    bus0.flush = 1'b1;
    bus0.en    = 1'b0;
    drive(0, 1'b1, 17'sd9, 17'sd9);
    @(negedge clk);
    bus0.flush = 1'b0;
    bus0.en    = 1'b1;
    drive(0, 1'b0, 17'sd0, 17'sd0);
    chk("flush_busy", bus0.busy, 0);
    chk("flush_ov", bus0.out_valid, 0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus0.out_valid) cnt++;
    end
    chk("flush_no_out", cnt, 0);
    run_one("post_flush", 0, 17'sd65535, 17'sd65535, 64'sd65534, 1'b0);

    // Reset pulse with entries in flight.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 17'sd1000, 17'(-200 - k));
      @(negedge clk);
    end
    drive(0, 1'b0, 17'sd0, 17'sd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_data", bus0.data_out, 0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus0.out_valid) cnt++;
    end
    chk("midrst_no_out", cnt, 0);
    run_one("post_rst", 0, -17'sd65536, 17'sd65535, -64'sd65535, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
